traffic_request_gen: RTL and testbench
======================================

# traffic_request_gen

Request generator feeding the traffic controller's mode inputs. It synchronizes and debounces the raw pedestrian push-button, and latches emergency-vehicle requests until the controller serves them. It also keeps a time-of-day counter that drives the day/night flag. It drives `pedSignal`, `emgSignal` and `dayTime` into TrafficMode and reads back its 2-bit `currentState` as the acknowledge.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples needed to accept a button level change (≥1).
- `TICKS_PER_HOUR`, 3600: clock cycles per simulated hour (≥2).
- `DAY_START`, 6: first hour of day, inclusive.
- `DAY_END`, 20: first hour of night; requires `DAY_START < DAY_END ≤ 24`.
- `RESET_HOUR`, 0: hour loaded on reset (0..23).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ped_btn`  in  1  raw pedestrian button, asynchronous.
- `emg_req`  in  1  raw emergency request level, asynchronous.
- `currentState`  in  2  controller state: 00 NIGHT, 01 DAY, 10 PED, 11 EMG.
- `pedSignal`  out  1  pending pedestrian request.
- `emgSignal`  out  1  active emergency request.
- `dayTime`  out  1  1 when `DAY_START ≤ hour < DAY_END`.
- `hour`  out  5  current hour, 0..23.

## Operation
- **Synchronizers.** `ped_btn` and `emg_req` each pass through a 2-flop synchronizer.
- **Debounce.**
  - The debouncer holds a stable level, reset to 0.
  - The counter increments while the synchronized level differs from the stable level, and clears otherwise.
  - When the count reaches `DEBOUNCE_CYCLES`, the stable level takes the new value.
- **Pedestrian latch.**
  - A stable-level rising edge sets `ped_pending`; `pedSignal = ped_pending`.
  - A sample of `currentState == PED` clears it.
  - An edge arriving while `currentState == PED` is discarded.
  - A pending request is retained during EMG.
- **Emergency FSM** with states IDLE, REQ, SERVED; `emgSignal = (state != IDLE)`.
  - IDLE → REQ when the synchronized `emg_req` is 1.
  - REQ → IDLE when the synchronized `emg_req` is 0 before service (cancelled alarm).
  - REQ → SERVED when `currentState == EMG`.
  - SERVED → IDLE when the synchronized `emg_req` is 0.
  - SERVED holds while the request remains high.
- **Clock of day.**
  - `tick` counts 0..`TICKS_PER_HOUR-1`.
  - At the terminal tick, `tick` returns to 0 and `hour` increments, wrapping 23 → 0.
  - `dayTime` is registered from the next-hour value, so it changes on the same edge as `hour`.
- **Reset.** `ped_pending`, the stable level, the debounce counter and the synchronizers clear to 0. The FSM goes to IDLE, `tick` to 0 and `hour` to `RESET_HOUR`.
- **Reset outputs.** `pedSignal = 0`, `emgSignal = 0`, `hour = RESET_HOUR`, and `dayTime` is the decoded value of `RESET_HOUR`.
- **Mid-operation reset.** Reset takes effect immediately, with no pending state retained.

## Timing
- Edge numbering: edge 1 is the first rising edge that samples a raw input high.
- `pedSignal` rises at edge `3 + DEBOUNCE_CYCLES` (macro on) or edge 3 (macro off).
- `pedSignal` falls on the edge that samples `currentState == PED`, so it is low the following cycle.
- `emgSignal` rises at edge 3 after `emg_req` rises. It falls at edge 3 after `emg_req` falls, in either REQ or SERVED.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `TRAFFIC_REQ_DEBOUNCE_EN`.
- Defined: the debounce counter is present as described, and `DEBOUNCE_CYCLES` is honoured.
- Undefined: the stable level equals the synchronized level, the counter is not instantiated, `DEBOUNCE_CYCLES` is ignored, and pedestrian latency is 3 edges.
- The emergency path is never debounced.

## Structure
- **Package `traffic_pkg`:**
  - `traffic_state_t` enum (NIGHT = 2'b00, DAY = 2'b01, PED = 2'b10, EMG = 2'b11);
  - `emg_state_t` enum (IDLE, REQ, SERVED);
  - `HOURS_PER_DAY = 24`.
- **Sub-module `req_debounce`:** synchronizer plus debounce counter. It is instantiated once for the button; the emergency synchronizer is a separate 2-flop stage.
- Width of `tick` is `$clog2(TICKS_PER_HOUR)`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `TICKS_PER_HOUR=4`, `DAY_START=6`, `DAY_END=20`, `RESET_HOUR=5`, macro defined.
- **Reset and day boundary:** hold `rst_n` low → `pedSignal=0`, `emgSignal=0`, `hour=5`, `dayTime=0`. Release → `hour=6` and `dayTime=1` on the 4th edge.
- **Pedestrian request:** `ped_btn` held high from edge 1 → `pedSignal=1` after edge 7. Drive `currentState=2'b10` for one cycle → `pedSignal=0` the next cycle. Further presses while PED → no new request.
- **Bounce rejection:** `ped_btn` toggles high 2 cycles / low 2 cycles for 40 cycles → `pedSignal` stays 0.
- **Emergency:**
  - `emg_req` high → `emgSignal=1` at edge 3.
  - Drop before `currentState=2'b11` → `emgSignal=0` 3 edges later.
  - Repeat with service: `emgSignal` stays 1 until `emg_req` drops, then 0 three edges later.
- **Wrap-around:** run to hour 19 → 20, `dayTime` falls. Continue hour 23 → 0, `hour=0`, `dayTime=0`.
- **Mid-operation reset:** with `pedSignal=1` and FSM in SERVED, pulse `rst_n` low asynchronously between edges → `pedSignal=0`, `emgSignal=0` and `hour=5` immediately, without waiting for an edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic controller request path.
// Controller state encoding, emergency FSM states and the day/night decode.
package traffic_pkg;

  localparam int unsigned HOURS_PER_DAY = 24;

  // Controller state as reported back on currentState.
  typedef enum logic [1:0] {
    NIGHT = 2'b00,
    DAY   = 2'b01,
    PED   = 2'b10,
    EMG   = 2'b11
  } traffic_state_t;

  // Emergency request tracking.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    SERVED = 2'b10
  } emg_state_t;

  // Day window is [dayStart, dayEnd).
  function automatic logic isDayHour(input logic [4:0]  hr,
                                     input int unsigned dayStart,
                                     input int unsigned dayEnd);
    int unsigned hrInt;
    hrInt = 32'(hr);
    return (hrInt >= dayStart) && (hrInt < dayEnd);
  endfunction

endpackage

// File: rtl/req_debounce.sv
// Two-flop synchronizer followed by an optional debounce counter.
// Build macro TRAFFIC_REQ_DEBOUNCE_EN: when defined, the output level only
// follows the synchronized input after DEBOUNCE_CYCLES consecutive differing
// samples; when undefined, the output is the synchronized input itself.
module req_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rawIn,
  output logic level
);

  if (DEBOUNCE_CYCLES < 1) begin : gBadDebounce
    $error("req_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1;
  logic sync2;

  // Metastability guard on the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= rawIn;
      sync2 <= sync1;
    end
  end

`ifdef TRAFFIC_REQ_DEBOUNCE_EN
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Counter runs 0..DEBOUNCE_CYCLES-1; the edge that would make it reach
  // DEBOUNCE_CYCLES instead commits the new level.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt;
  logic            stable;

  // Count consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CntLast) begin
      cnt    <= '0;
      stable <= sync2;
    end else begin
      cnt <= cnt + CntW'(1);
    end
  end

  assign level = stable;
`else
  assign level = sync2;
`endif

endmodule

// File: rtl/traffic_request_gen.sv
// Request generator for the traffic controller mode inputs.
// Debounces the pedestrian button into a pending request, tracks emergency
// requests until served, and keeps a time-of-day clock driving dayTime.
// Build macro TRAFFIC_REQ_DEBOUNCE_EN enables the pedestrian debounce counter.
module traffic_request_gen
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICKS_PER_HOUR  = 3600,
  parameter int unsigned DAY_START       = 6,
  parameter int unsigned DAY_END         = 20,
  parameter int unsigned RESET_HOUR      = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_btn,
  input  logic       emg_req,
  input  logic [1:0] currentState,
  output logic       pedSignal,
  output logic       emgSignal,
  output logic       dayTime,
  output logic [4:0] hour
);

  if (TICKS_PER_HOUR < 2) begin : gBadTicks
    $error("traffic_request_gen: TICKS_PER_HOUR must be at least 2");
  end
  if (!(DAY_START < DAY_END && DAY_END <= HOURS_PER_DAY)) begin : gBadDay
    $error("traffic_request_gen: need DAY_START < DAY_END <= 24");
  end
  if (RESET_HOUR >= HOURS_PER_DAY) begin : gBadResetHour
    $error("traffic_request_gen: RESET_HOUR must be 0..23");
  end

  localparam int unsigned     TickW     = $clog2(TICKS_PER_HOUR);
  localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_HOUR - 1);
  localparam logic [4:0]      ResetHour = 5'(RESET_HOUR);
  localparam logic [4:0]      LastHour  = 5'(HOURS_PER_DAY - 1);

  traffic_state_t ctrlState;
  assign ctrlState = traffic_state_t'(currentState);

  // ---------------------------------------------------------------------------
  // Pedestrian request
  // ---------------------------------------------------------------------------
  logic pedLevel;
  logic pedLevelPrev;
  logic pedRise;
  logic pedPending;

  req_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uPedDebounce (
    .clk  (clk),
    .rst_n(rst_n),
    .rawIn(ped_btn),
    .level(pedLevel)
  );

  assign pedRise = pedLevel & ~pedLevelPrev;

  // Latch a press until the controller is seen in PED; presses during PED are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pedLevelPrev <= 1'b0;
      pedPending   <= 1'b0;
    end else begin
      pedLevelPrev <= pedLevel;
      if (ctrlState == PED) begin
        pedPending <= 1'b0;
      end else if (pedRise) begin
        pedPending <= 1'b1;
      end
    end
  end

  assign pedSignal = pedPending;

  // ---------------------------------------------------------------------------
  // Emergency request (never debounced)
  // ---------------------------------------------------------------------------
  logic       emgSync1;
  logic       emgSync2;
  emg_state_t emgState;

  // Synchronize the raw emergency level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emgSync1 <= 1'b0;
      emgSync2 <= 1'b0;
    end else begin
      emgSync1 <= emg_req;
      emgSync2 <= emgSync1;
    end
  end

  // Emergency FSM; emgSignal is registered alongside the state it reflects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emgState  <= IDLE;
      emgSignal <= 1'b0;
    end else begin
      unique case (emgState)
        IDLE: begin
          if (emgSync2) begin
            emgState  <= REQ;
            emgSignal <= 1'b1;
          end
        end
        REQ: begin
          // A dropped request wins over service arriving on the same edge.
          if (!emgSync2) begin
            emgState  <= IDLE;
            emgSignal <= 1'b0;
          end else if (ctrlState == EMG) begin
            emgState <= SERVED;
          end
        end
        SERVED: begin
          if (!emgSync2) begin
            emgState  <= IDLE;
            emgSignal <= 1'b0;
          end
        end
        default: begin
          emgState  <= IDLE;
          emgSignal <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Time of day
  // ---------------------------------------------------------------------------
  logic [TickW-1:0] tick;
  logic [TickW-1:0] tickNext;
  logic [4:0]       hourNext;

  // Next tick/hour, wrapping tick at TICKS_PER_HOUR and hour at 24.
  always_comb begin
    tickNext = tick + TickW'(1);
    hourNext = hour;
    if (tick == TickLast) begin
      tickNext = '0;
      hourNext = (hour == LastHour) ? 5'd0 : hour + 5'd1;
    end
  end

  // dayTime decodes the next hour so it switches on the same edge as hour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick    <= '0;
      hour    <= ResetHour;
      dayTime <= isDayHour(ResetHour, DAY_START, DAY_END);
    end else begin
      tick    <= tickNext;
      hour    <= hourNext;
      dayTime <= isDayHour(hourNext, DAY_START, DAY_END);
    end
  end

endmodule

// File: tb/tb_traffic_request_gen.sv
// Directed bench for traffic_request_gen with TICKS_PER_HOUR=4, RESET_HOUR=5.
module tb_traffic_request_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ped_btn;
  logic       emg_req;
  logic [1:0] currentState;
  logic       pedSignal;
  logic       emgSignal;
  logic       dayTime;
  logic [4:0] hour;

  int errors = 0;
  int checks = 0;

`ifdef TRAFFIC_REQ_DEBOUNCE_EN
  localparam int PedLat = 3 + 4;
`else
  localparam int PedLat = 3;
`endif

  always #5 clk = ~clk;

  traffic_request_gen #(
    .DEBOUNCE_CYCLES(4),
    .TICKS_PER_HOUR (4),
    .DAY_START      (6),
    .DAY_END        (20),
    .RESET_HOUR     (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ped_btn     (ped_btn),
    .emg_req     (emg_req),
    .currentState(currentState),
    .pedSignal   (pedSignal),
    .emgSignal   (emgSignal),
    .dayTime     (dayTime),
    .hour        (hour)
  );

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset and release just after an edge; the next rising edge is edge 1.
  task automatic applyReset();
    rst_n        = 1'b0;
    ped_btn      = 1'b0;
    emg_req      = 1'b0;
    currentState = 2'b01;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    ped_btn      = 1'b0;
    emg_req      = 1'b0;
    currentState = 2'b00;
    step(2);
    checks++; if (pedSignal !== 1'b0) begin errors++; $display("FAIL reset_ped: got %b want 0", pedSignal); end
    checks++; if (emgSignal !== 1'b0) begin errors++; $display("FAIL reset_emg: got %b want 0", emgSignal); end
    checks++; if (hour !== 5'd5) begin errors++; $display("FAIL reset_hour: got %0d want 5", hour); end
    checks++; if (dayTime !== 1'b0) begin errors++; $display("FAIL reset_day: got %b want 0", dayTime); end
    rst_n = 1'b1;
    step(3);
    checks++; if (hour !== 5'd5) begin errors++; $display("FAIL edge3_hour: got %0d want 5", hour); end
    step(1);
    checks++; if (hour !== 5'd6) begin errors++; $display("FAIL edge4_hour: got %0d want 6", hour); end
    checks++; if (dayTime !== 1'b1) begin errors++; $display("FAIL edge4_day: got %b want 1", dayTime); end
  endtask

  task automatic test_pedestrian();
    applyReset();
    ped_btn = 1'b1;
    step(PedLat - 1);
    checks++; if (pedSignal !== 1'b0) begin errors++; $display("FAIL ped_early: got %b want 0", pedSignal); end
    step(1);
    checks++; if (pedSignal !== 1'b1) begin errors++; $display("FAIL ped_rise: got %b want 1", pedSignal); end
    currentState = 2'b10;
    step(1);
    checks++; if (pedSignal !== 1'b0) begin errors++; $display("FAIL ped_served: got %b want 0", pedSignal); end
    currentState = 2'b01;
    step(1);
    checks++; if (pedSignal !== 1'b0) begin errors++; $display("FAIL ped_stay_low: got %b want 0", pedSignal); end
    // New press entirely within PED must be discarded.
    currentState = 2'b10;
    ped_btn = 1'b0;
    step(12);
    ped_btn = 1'b1;
    step(12);
    currentState = 2'b01;
    step(3);
    checks++; if (pedSignal !== 1'b0) begin errors++; $display("FAIL ped_during_ped: got %b want 0", pedSignal); end
    // A pending request survives EMG.
    ped_btn = 1'b0;
    step(12);
    ped_btn = 1'b1;
    step(PedLat);
    checks++; if (pedSignal !== 1'b1) begin errors++; $display("FAIL ped_second: got %b want 1", pedSignal); end
    currentState = 2'b11;
    step(5);
    checks++; if (pedSignal !== 1'b1) begin errors++; $display("FAIL ped_in_emg: got %b want 1", pedSignal); end
    currentState = 2'b01;
    ped_btn = 1'b0;
  endtask

  task automatic test_bounce();
    applyReset();
    for (int i = 0; i < 40; i++) begin
      ped_btn = ((i / 2) % 2) == 0;
      step(1);
`ifdef TRAFFIC_REQ_DEBOUNCE_EN
      checks++; if (pedSignal !== 1'b0) begin errors++; $display("FAIL bounce_cycle%0d: got %b want 0", i, pedSignal); end
`endif
    end
    ped_btn = 1'b0;
    step(PedLat + 2);
`ifdef TRAFFIC_REQ_DEBOUNCE_EN
    checks++; if (pedSignal !== 1'b0) begin errors++; $display("FAIL bounce_end: got %b want 0", pedSignal); end
`else
    checks++; if (pedSignal !== 1'b1) begin errors++; $display("FAIL bounce_end: got %b want 1", pedSignal); end
`endif
  endtask

  task automatic test_emergency();
    applyReset();
    emg_req = 1'b1;
    step(2);
    checks++; if (emgSignal !== 1'b0) begin errors++; $display("FAIL emg_early: got %b want 0", emgSignal); end
    step(1);
    checks++; if (emgSignal !== 1'b1) begin errors++; $display("FAIL emg_rise: got %b want 1", emgSignal); end
    emg_req = 1'b0;
    step(2);
    checks++; if (emgSignal !== 1'b1) begin errors++; $display("FAIL emg_cancel_early: got %b want 1", emgSignal); end
    step(1);
    checks++; if (emgSignal !== 1'b0) begin errors++; $display("FAIL emg_cancel: got %b want 0", emgSignal); end
    emg_req = 1'b1;
    step(3);
    checks++; if (emgSignal !== 1'b1) begin errors++; $display("FAIL emg_rise2: got %b want 1", emgSignal); end
    currentState = 2'b11;
    step(2);
    currentState = 2'b01;
    step(5);
    checks++; if (emgSignal !== 1'b1) begin errors++; $display("FAIL emg_served_hold: got %b want 1", emgSignal); end
    emg_req = 1'b0;
    step(2);
    checks++; if (emgSignal !== 1'b1) begin errors++; $display("FAIL emg_drop_early: got %b want 1", emgSignal); end
    step(1);
    checks++; if (emgSignal !== 1'b0) begin errors++; $display("FAIL emg_drop: got %b want 0", emgSignal); end
  endtask

  task automatic test_wrap();
    applyReset();
    step(59);
    checks++; if (hour !== 5'd19) begin errors++; $display("FAIL wrap_h19: got %0d want 19", hour); end
    checks++; if (dayTime !== 1'b1) begin errors++; $display("FAIL wrap_day19: got %b want 1", dayTime); end
    step(1);
    checks++; if (hour !== 5'd20) begin errors++; $display("FAIL wrap_h20: got %0d want 20", hour); end
    checks++; if (dayTime !== 1'b0) begin errors++; $display("FAIL wrap_day20: got %b want 0", dayTime); end
    step(15);
    checks++; if (hour !== 5'd23) begin errors++; $display("FAIL wrap_h23: got %0d want 23", hour); end
    step(1);
    checks++; if (hour !== 5'd0) begin errors++; $display("FAIL wrap_h0: got %0d want 0", hour); end
    checks++; if (dayTime !== 1'b0) begin errors++; $display("FAIL wrap_day0: got %b want 0", dayTime); end
    step(24);
    checks++; if (hour !== 5'd6) begin errors++; $display("FAIL wrap_h6: got %0d want 6", hour); end
    checks++; if (dayTime !== 1'b1) begin errors++; $display("FAIL wrap_day6: got %b want 1", dayTime); end
  endtask

  task automatic test_mid_reset();
    applyReset();
    ped_btn = 1'b1;
    emg_req = 1'b1;
    step(PedLat + 1);
    currentState = 2'b11;
    step(2);
    checks++; if (pedSignal !== 1'b1) begin errors++; $display("FAIL mid_pre_ped: got %b want 1", pedSignal); end
    checks++; if (emgSignal !== 1'b1) begin errors++; $display("FAIL mid_pre_emg: got %b want 1", emgSignal); end
    // Assert reset between edges and check before any further edge.
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (pedSignal !== 1'b0) begin errors++; $display("FAIL mid_ped: got %b want 0", pedSignal); end
    checks++; if (emgSignal !== 1'b0) begin errors++; $display("FAIL mid_emg: got %b want 0", emgSignal); end
    checks++; if (hour !== 5'd5) begin errors++; $display("FAIL mid_hour: got %0d want 5", hour); end
    checks++; if (dayTime !== 1'b0) begin errors++; $display("FAIL mid_day: got %b want 0", dayTime); end
    rst_n = 1'b1;
    step(2);
    checks++; if (emgSignal !== 1'b0) begin errors++; $display("FAIL mid_emg_relatch_early: got %b want 0", emgSignal); end
    step(1);
    checks++; if (emgSignal !== 1'b1) begin errors++; $display("FAIL mid_emg_relatch: got %b want 1", emgSignal); end
    emg_req = 1'b0;
    ped_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pedestrian();
    test_bounce();
    test_emergency();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
